rs_issue_sched: RTL and testbench
=================================

Name: rs_issue_sched

Overview:
- Scheduler for one bank of NUM_RS single-entry reservation stations.
- Each cycle it allocates free entries to up to DISPATCH_WIDTH dispatched instructions and asserts their load strobes.
- Among entries whose wake-up vector targets a ready functional unit, it selects the oldest (ROB order) per FU and drives registered per-entry issue enables plus per-FU selected-entry indices to the operand/FU muxes.
- It tracks bank occupancy with a counter and handles pipeline flush.

Parameters:
- NUM_RS, 16, number of RS entries in the bank.
- ISSUE_WIDTH, 3, number of FUs (wake-up vector width).
- DISPATCH_WIDTH, 3, dispatch slots per cycle.
- ROB_WIDTH, 5, ROB index width; ages are ROB_WIDTH+1 bits (MSB = wrap bit).
- IDX_W, $clog2(NUM_RS), entry index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- pipe_flush  in  1  squash all scheduling state.
- rs_wake_up  in  NUM_RS*ISSUE_WIDTH  entry e bits [e*ISSUE_WIDTH +: ISSUE_WIDTH]; registered per-entry ready-for-FU vector.
- rs_avail  in  NUM_RS  entry free.
- rs_age  in  NUM_RS*(ROB_WIDTH+1)  per-entry ROB tag.
- rob_head  in  ROB_WIDTH+1  ROB head tag including wrap bit.
- fu_ready  in  ISSUE_WIDTH  FU can accept an op this cycle.
- dispatch_valid  in  DISPATCH_WIDTH  dispatch slot k carries an instruction.
- rs_load  out  NUM_RS  combinational per-entry load strobe.
- dispatch_rs_idx  out  DISPATCH_WIDTH*IDX_W  combinational entry assigned to slot k.
- dispatch_stall  out  1  combinational; bank cannot accept this cycle's group.
- rs_use_en  out  NUM_RS  registered per-entry issue enable.
- issue_valid  out  ISSUE_WIDTH  registered; FU f receives an op.
- issue_idx  out  ISSUE_WIDTH*IDX_W  registered; entry feeding FU f.
- free_count  out  IDX_W+1  registered count of free entries.

Behaviour:
- Reset: on posedge clk with rst_n=0, the following take these values: rs_use_en=0, issue_valid=0, issue_idx=0, free_count=NUM_RS. Combinational outputs follow their equations.
- Age compare:
  - rel_e = (rs_age_e - rob_head) mod 2^(ROB_WIDTH+1); smaller rel_e is older.
  - Equal rel_e: lower entry index wins.
- Candidate set for FU f: entry e with rs_wake_up[e][f]=1, rs_avail[e]=0, rs_use_en[e]=0, and f equal to the lowest set bit of rs_wake_up[e].
  - The rs_use_en[e]=0 term masks entries granted last cycle, whose wake-up is still high.
  - The lowest-set-bit term means an entry is never granted to two FUs.
- Grant for FU f:
  - If fu_ready[f]=1, pipe_flush=0 and the candidate set is non-empty, grant the oldest candidate.
  - Next cycle: issue_valid[f]=1, issue_idx[f]=winner, rs_use_en[winner]=1.
  - Otherwise issue_valid[f]=0 and issue_idx[f] holds its value.
- Issue latency: one cycle from wake-up visible to rs_use_en. rs_use_en is a one-cycle pulse per grant.
- Dispatch:
  - n_free = popcount(rs_avail); n_req = popcount(dispatch_valid).
  - dispatch_stall = pipe_flush | (n_req > n_free).
  - If not stalled, valid slots in ascending slot order take free entries in ascending index order.
  - rs_load is set for the assigned entries; dispatch_rs_idx[k] is that entry's index.
  - If stalled, rs_load=0 (all-or-nothing). dispatch_rs_idx for invalid/stalled slots = 0.
- Occupancy: free_count <= free_count + popcount(rs_use_en) - popcount(rs_load).
  - Invariant: free_count equals popcount(rs_avail) every cycle; the bench checks this.
- Flush: pipe_flush=1 at an edge sets free_count=NUM_RS, rs_use_en=0, issue_valid=0. No grants and no loads are made during a flush cycle.
- Boundaries:
  - Bank full (n_free=0) with any dispatch_valid: stall.
  - All fu_ready=0: no issue, wake-ups persist.
  - Age wrap: rob_head=6'h3E, ages 6'h3F and 6'h01 give rel 1 and 3; 6'h3F wins.
  - Simultaneous load into entry X and issue from entry Y in the same cycle is legal; free_count is unchanged.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, all rs_avail=1 -> rs_use_en=0, issue_valid=0, free_count=16, dispatch_stall=0.
2. dispatch_valid=3'b101, rs_avail=16'hFFF0 -> rs_load=16'h0030, dispatch_rs_idx slot0=4, slot2=5, free_count decrements by 2 next cycle.
3. Entries 2 (age 6'h05) and 9 (age 6'h03) both wake FU1, rob_head=0 -> next cycle rs_use_en=16'h0200, issue_idx[1]=9. Following cycle entry 2 wins while entry 9's wake-up is still high (entry 9 masked).
4. Wrap: rob_head=6'h3E, entry 0 age 6'h01, entry 1 age 6'h3F, both FU0 -> issue_idx[0]=1.
5. 14 entries busy, dispatch_valid=3'b111 -> dispatch_stall=1, rs_load=0.
6. pipe_flush mid-issue with grants pending -> next cycle issue_valid=0, rs_use_en=0, free_count=16; no rs_load during the flush cycle.

Source files
------------

// File: rtl/rs_issue_sched.sv
// Issue scheduler for one bank of single-entry reservation stations: allocates free
// entries to dispatched instructions and picks the oldest ready entry per functional unit.
module rs_issue_sched #(
  parameter int NUM_RS         = 16,
  parameter int ISSUE_WIDTH    = 3,
  parameter int DISPATCH_WIDTH = 3,
  parameter int ROB_WIDTH      = 5,
  parameter int IDX_W          = $clog2(NUM_RS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pipe_flush,
  input  logic [NUM_RS*ISSUE_WIDTH-1:0]     rs_wake_up,
  input  logic [NUM_RS-1:0]                 rs_avail,
  input  logic [NUM_RS*(ROB_WIDTH+1)-1:0]   rs_age,
  input  logic [ROB_WIDTH:0]                rob_head,
  input  logic [ISSUE_WIDTH-1:0]            fu_ready,
  input  logic [DISPATCH_WIDTH-1:0]         dispatch_valid,
  output logic [NUM_RS-1:0]                 rs_load,
  output logic [DISPATCH_WIDTH*IDX_W-1:0]   dispatch_rs_idx,
  output logic                              dispatch_stall,
  output logic [NUM_RS-1:0]                 rs_use_en,
  output logic [ISSUE_WIDTH-1:0]            issue_valid,
  output logic [ISSUE_WIDTH*IDX_W-1:0]      issue_idx,
  output logic [IDX_W:0]                    free_count
);
  localparam int AGE_W = ROB_WIDTH + 1;

  logic [NUM_RS-1:0]              rs_use_en_q, rs_use_en_d;
  logic [ISSUE_WIDTH-1:0]         issue_valid_q;
  logic [ISSUE_WIDTH*IDX_W-1:0]   issue_idx_q, issue_idx_d;
  logic [IDX_W:0]                 free_count_q, free_count_d;

  logic [AGE_W-1:0]       rel [NUM_RS];
  logic [ISSUE_WIDTH-1:0] elig [NUM_RS];
  logic [IDX_W-1:0]       grant_idx [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] grant;

  genvar gi;

  // Distance from the ROB head makes the compare immune to tag wrap-around.
  for (gi = 0; gi < NUM_RS; gi++) begin : g_entry
    logic [ISSUE_WIDTH-1:0] wake;
    assign wake     = rs_wake_up[gi*ISSUE_WIDTH +: ISSUE_WIDTH];
    assign rel[gi]  = rs_age[gi*AGE_W +: AGE_W] - rob_head;
    assign elig[gi] = (wake & (-wake)) & {ISSUE_WIDTH{~rs_avail[gi] & ~rs_use_en_q[gi]}};
  end

  for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_fu
    logic             found;
    logic [IDX_W-1:0] best_idx;
    logic [AGE_W-1:0] best_rel;
    // Strict less-than keeps the lower index on equal age.
    always_comb begin
      found    = 1'b0;
      best_idx = '0;
      best_rel = '0;
      for (int e = 0; e < NUM_RS; e++) begin
        if (elig[e][gi] && (!found || (rel[e] < best_rel))) begin
          found    = 1'b1;
          best_idx = IDX_W'(e);
          best_rel = rel[e];
        end
      end
    end
    assign grant[gi]     = found & fu_ready[gi] & ~pipe_flush;
    assign grant_idx[gi] = best_idx;
  end

  always_comb begin
    rs_use_en_d = '0;
    issue_idx_d = issue_idx_q;
    for (int f = 0; f < ISSUE_WIDTH; f++) begin
      if (grant[f]) begin
        rs_use_en_d[grant_idx[f]]      = 1'b1;
        issue_idx_d[f*IDX_W +: IDX_W] = grant_idx[f];
      end
    end
  end

  logic [IDX_W:0]      n_free, n_req;
  logic [NUM_RS-1:0]   remaining;
  logic                slot_found;

  // All-or-nothing allocation: slots in order take the lowest still-free entries.
  always_comb begin
    n_free          = '0;
    n_req           = '0;
    rs_load         = '0;
    dispatch_rs_idx = '0;
    remaining       = rs_avail;
    slot_found      = 1'b0;
    for (int e = 0; e < NUM_RS; e++) n_free = n_free + (IDX_W+1)'(rs_avail[e]);
    for (int k = 0; k < DISPATCH_WIDTH; k++) n_req = n_req + (IDX_W+1)'(dispatch_valid[k]);
    dispatch_stall = pipe_flush | (n_req > n_free);
    if (!dispatch_stall) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        slot_found = 1'b0;
        if (dispatch_valid[k]) begin
          for (int e = 0; e < NUM_RS; e++) begin
            if (!slot_found && remaining[e]) begin
              slot_found                        = 1'b1;
              remaining[e]                      = 1'b0;
              rs_load[e]                        = 1'b1;
              dispatch_rs_idx[k*IDX_W +: IDX_W] = IDX_W'(e);
            end
          end
        end
      end
    end
  end

  always_comb begin
    free_count_d = free_count_q;
    for (int e = 0; e < NUM_RS; e++) begin
      free_count_d = free_count_d + (IDX_W+1)'(rs_use_en_q[e]) - (IDX_W+1)'(rs_load[e]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_use_en_q   <= '0;
      issue_valid_q <= '0;
      issue_idx_q   <= '0;
      free_count_q  <= (IDX_W+1)'(NUM_RS);
    end else if (pipe_flush) begin
      rs_use_en_q   <= '0;
      issue_valid_q <= '0;
      free_count_q  <= (IDX_W+1)'(NUM_RS);
    end else begin
      rs_use_en_q   <= rs_use_en_d;
      issue_valid_q <= grant;
      issue_idx_q   <= issue_idx_d;
      free_count_q  <= free_count_d;
    end
  end

  assign rs_use_en   = rs_use_en_q;
  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;
  assign free_count  = free_count_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: dispatch allocation, oldest-first issue, wrap,
// stall boundaries, simultaneous load/issue and flush, with occupancy tracking.
module tb_rs_issue_sched;
  logic         clk;
  logic         rst_n;
  logic         pipe_flush;
  logic [47:0]  rs_wake_up;
  logic [15:0]  rs_avail;
  logic [95:0]  rs_age;
  logic [5:0]   rob_head;
  logic [2:0]   fu_ready;
  logic [2:0]   dispatch_valid;
  logic [15:0]  rs_load;
  logic [11:0]  dispatch_rs_idx;
  logic         dispatch_stall;
  logic [15:0]  rs_use_en;
  logic [2:0]   issue_valid;
  logic [11:0]  issue_idx;
  logic [4:0]   free_count;

  int checks = 0;
  int errors = 0;

  rs_issue_sched dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .rs_wake_up(rs_wake_up),
    .rs_avail(rs_avail), .rs_age(rs_age), .rob_head(rob_head), .fu_ready(fu_ready),
    .dispatch_valid(dispatch_valid), .rs_load(rs_load), .dispatch_rs_idx(dispatch_rs_idx),
    .dispatch_stall(dispatch_stall), .rs_use_en(rs_use_en), .issue_valid(issue_valid),
    .issue_idx(issue_idx), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wake(input int e, input logic [2:0] v);
    rs_wake_up[e*3 +: 3] = v;
  endtask

  task automatic set_age(input int e, input logic [5:0] v);
    rs_age[e*6 +: 6] = v;
  endtask

  task automatic check_regs(input string name, input logic [15:0] use_en,
                            input logic [2:0] valid, input logic [4:0] fc);
    checks++;
    if (rs_use_en !== use_en || issue_valid !== valid || free_count !== fc) begin
      errors++;
      $display("FAIL %s: got use_en=%h valid=%b free=%0d exp use_en=%h valid=%b free=%0d",
               name, rs_use_en, issue_valid, free_count, use_en, valid, fc);
    end
    $display("txn %s: use_en=%h valid=%b idx=%h free=%0d", name, rs_use_en, issue_valid,
             issue_idx, free_count);
  endtask

  task automatic check_invariant(input string name);
    checks++;
    if (free_count !== 5'($countones(rs_avail))) begin
      errors++;
      $display("FAIL %s_occupancy: got free=%0d exp %0d", name, free_count, $countones(rs_avail));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pipe_flush = 1'b0; rs_wake_up = '0; rs_avail = 16'hFFFF; rs_age = '0;
    rob_head = '0; fu_ready = 3'b111; dispatch_valid = '0;
    edge_sample();
    edge_sample();
    check_regs("reset", 16'h0000, 3'b000, 5'd16);
    checks++;
    if (issue_idx !== 12'h000 || dispatch_stall !== 1'b0 || rs_load !== 16'h0000) begin
      errors++;
      $display("FAIL reset_comb: got idx=%h stall=%b load=%h exp idx=000 stall=0 load=0000",
               issue_idx, dispatch_stall, rs_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Table rows: dispatch_valid, rs_avail, expected load, idx, stall, free_count after edge.
  task automatic run_dispatch_table(input string name, input int n,
                                    input logic [2:0] dv [8], input logic [15:0] av [8],
                                    input logic [15:0] ld [8], input logic [11:0] ix [8],
                                    input logic st [8], input logic [4:0] fc [8]);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rs_avail = av[i];
      dispatch_valid = dv[i];
      #1;
      check_invariant(name);
      checks++;
      if (rs_load !== ld[i] || dispatch_rs_idx !== ix[i] || dispatch_stall !== st[i]) begin
        errors++;
        $display("FAIL %s_row%0d: got load=%h idx=%h stall=%b exp load=%h idx=%h stall=%b",
                 name, i, rs_load, dispatch_rs_idx, dispatch_stall, ld[i], ix[i], st[i]);
      end
      edge_sample();
      checks++;
      if (free_count !== fc[i]) begin
        errors++;
        $display("FAIL %s_free%0d: got %0d exp %0d", name, i, free_count, fc[i]);
      end
      $display("txn %s row %0d: dv=%b load=%h idx=%h stall=%b free=%0d", name, i, dv[i],
               rs_load, dispatch_rs_idx, dispatch_stall, free_count);
    end
    @(negedge clk);
    dispatch_valid = '0;
  endtask

  task automatic test_dispatch();
    logic [2:0] dv [8]; logic [15:0] av [8]; logic [15:0] ld [8];
    logic [11:0] ix [8]; logic st [8]; logic [4:0] fc [8];
    dv = '{3'b111, 3'b001, 3'b101, 3'b111, 3'b001, 0, 0, 0};
    av = '{16'hFFFF, 16'hFFF8, 16'hFFF0, 16'hFFC0, 16'hFE00, 0, 0, 0};
    ld = '{16'h0007, 16'h0008, 16'h0030, 16'h01C0, 16'h0200, 0, 0, 0};
    ix = '{12'h210, 12'h003, 12'h504, 12'h876, 12'h009, 0, 0, 0};
    st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    fc = '{5'd13, 5'd12, 5'd10, 5'd7, 5'd6, 0, 0, 0};
    run_dispatch_table("dispatch", 5, dv, av, ld, ix, st, fc);
  endtask

  task automatic test_oldest_first();
    rs_avail = 16'hFC00; rob_head = 6'h00;
    set_age(2, 6'h05); set_age(9, 6'h03);
    set_wake(2, 3'b010); set_wake(9, 3'b010);
    #1;
    check_invariant("oldest");
    edge_sample();
    check_regs("oldest_e9", 16'h0200, 3'b010, 5'd6);
    checks++;
    if (issue_idx[7:4] !== 4'd9) begin
      errors++;
      $display("FAIL oldest_idx9: got %0d exp 9", issue_idx[7:4]);
    end
    edge_sample();
    check_regs("masked_e2", 16'h0004, 3'b010, 5'd7);
    checks++;
    if (issue_idx[7:4] !== 4'd2) begin
      errors++;
      $display("FAIL masked_idx2: got %0d exp 2", issue_idx[7:4]);
    end
    @(negedge clk);
    rs_avail = 16'hFE00; set_wake(9, 3'b000);
    #1;
    check_invariant("oldest_free9");
    edge_sample();
    check_regs("oldest_idle", 16'h0000, 3'b000, 5'd8);
    checks++;
    if (issue_idx[7:4] !== 4'd2) begin
      errors++;
      $display("FAIL hold_idx: got %0d exp 2", issue_idx[7:4]);
    end
    @(negedge clk);
    rs_avail = 16'hFE04; set_wake(2, 3'b000);
  endtask

  task automatic test_age_wrap();
    rob_head = 6'h3E;
    set_age(0, 6'h01); set_age(1, 6'h3F);
    set_wake(0, 3'b001); set_wake(1, 3'b001);
    #1;
    check_invariant("wrap");
    edge_sample();
    check_regs("wrap_e1", 16'h0002, 3'b001, 5'd8);
    checks++;
    if (issue_idx !== 12'h021) begin
      errors++;
      $display("FAIL wrap_idx: got %h exp 021", issue_idx);
    end
    edge_sample();
    check_regs("wrap_e0", 16'h0001, 3'b001, 5'd9);
    @(negedge clk);
    rs_avail = 16'hFE06; set_wake(1, 3'b000);
    edge_sample();
    check_regs("wrap_idle", 16'h0000, 3'b000, 5'd10);
    @(negedge clk);
    rs_avail = 16'hFE07; set_wake(0, 3'b000);
  endtask

  task automatic test_fu_not_ready();
    fu_ready = 3'b000;
    set_wake(3, 3'b100); set_wake(4, 3'b110);
    #1;
    check_invariant("fu_busy");
    edge_sample();
    check_regs("fu_busy", 16'h0000, 3'b000, 5'd10);
    @(negedge clk);
    fu_ready = 3'b111;
    edge_sample();
    check_regs("fu_ready", 16'h0018, 3'b110, 5'd10);
    checks++;
    if (issue_idx[11:4] !== 8'h34) begin
      errors++;
      $display("FAIL lowbit_idx: got %h exp 34", issue_idx[11:4]);
    end
    @(negedge clk);
    set_wake(3, 3'b000); set_wake(4, 3'b000);
    edge_sample();
    check_regs("fu_idle", 16'h0000, 3'b000, 5'd12);
    @(negedge clk);
    rs_avail = 16'hFE1F;
  endtask

  task automatic test_stall();
    logic [2:0] dv [8]; logic [15:0] av [8]; logic [15:0] ld [8];
    logic [11:0] ix [8]; logic st [8]; logic [4:0] fc [8];
    dv = '{3'b111, 3'b111, 3'b111, 3'b001, 3'b111, 3'b011, 3'b001, 0};
    av = '{16'hFE1F, 16'hFE18, 16'hFC00, 16'hE000, 16'hC000, 16'hC000, 16'h0000, 0};
    ld = '{16'h0007, 16'h0218, 16'h1C00, 16'h2000, 16'h0000, 16'hC000, 16'h0000, 0};
    ix = '{12'h210, 12'h943, 12'hCBA, 12'h00D, 12'h000, 12'h0FE, 12'h000, 0};
    st = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    fc = '{5'd9, 5'd6, 5'd3, 5'd2, 5'd2, 5'd0, 5'd0, 0};
    run_dispatch_table("stall", 7, dv, av, ld, ix, st, fc);
  endtask

  task automatic test_back_to_back();
    rob_head = 6'h00;
    set_age(5, 6'h00); set_age(6, 6'h01);
    set_wake(5, 3'b001); set_wake(6, 3'b001);
    edge_sample();
    check_regs("b2b_e5", 16'h0020, 3'b001, 5'd0);
    @(negedge clk);
    set_wake(5, 3'b000);
    edge_sample();
    check_regs("b2b_e6", 16'h0040, 3'b001, 5'd1);
    @(negedge clk);
    rs_avail = 16'h0020; set_wake(6, 3'b000); dispatch_valid = 3'b001;
    #1;
    checks++;
    if (rs_load !== 16'h0020 || dispatch_rs_idx !== 12'h005 || dispatch_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load: got load=%h idx=%h stall=%b exp load=0020 idx=005 stall=0",
               rs_load, dispatch_rs_idx, dispatch_stall);
    end
    edge_sample();
    check_regs("b2b_same", 16'h0000, 3'b000, 5'd1);
    @(negedge clk);
    rs_avail = 16'h0040; dispatch_valid = '0;
    #1;
    check_invariant("b2b");
  endtask

  task automatic test_flush();
    set_wake(0, 3'b001); set_wake(1, 3'b010);
    edge_sample();
    check_regs("pre_flush", 16'h0003, 3'b011, 5'd1);
    @(negedge clk);
    pipe_flush = 1'b1; set_wake(2, 3'b100); dispatch_valid = 3'b001;
    #1;
    checks++;
    if (dispatch_stall !== 1'b1 || rs_load !== 16'h0000) begin
      errors++;
      $display("FAIL flush_comb: got stall=%b load=%h exp stall=1 load=0000",
               dispatch_stall, rs_load);
    end
    edge_sample();
    check_regs("flush", 16'h0000, 3'b000, 5'd16);
    checks++;
    if (issue_idx !== 12'h310) begin
      errors++;
      $display("FAIL flush_idx_hold: got %h exp 310", issue_idx);
    end
    @(negedge clk);
    pipe_flush = 1'b0; rs_avail = 16'hFFFF; rs_wake_up = '0; dispatch_valid = '0;
    #1;
    check_invariant("flush");
    edge_sample();
    check_regs("post_flush", 16'h0000, 3'b000, 5'd16);
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_oldest_first();
    test_age_wrap();
    test_fu_not_ready();
    test_stall();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
